// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage_if
//  Purpose  : Decode-side, bypass-network and ALU-side signals of the ID/EX operand stage
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 4
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [DATA_W-1:0]     id_rs1_data;
    logic [DATA_W-1:0]     id_rs2_data;
    logic [DATA_W-1:0]     id_imm;
    logic                  id_use_imm;
    logic [ALUOP_W-1:0]    id_aluop;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  hold;
    logic                  flush;
    logic                  exm_regwrite;
    logic [REG_ADDR_W-1:0] exm_rd;
    logic [DATA_W-1:0]     exm_result;
    logic                  mwb_regwrite;
    logic [REG_ADDR_W-1:0] mwb_rd;
    logic [DATA_W-1:0]     mwb_result;
    logic [DATA_W-1:0]     data1;
    logic [DATA_W-1:0]     data2;
    logic [ALUOP_W-1:0]    aluoperation;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic [DATA_W-1:0]     ex_rs2_fwd;
    logic                  load_use_stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_use_imm, id_aluop, id_regwrite, id_memread, hold, flush,
               exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_result,
        input  data1, data2, aluoperation, ex_valid, ex_rd, ex_regwrite, ex_memread,
               ex_rs2_fwd, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_use_imm, id_aluop, id_regwrite, id_memread, hold, flush,
               exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_result,
        output data1, data2, aluoperation, ex_valid, ex_rd, ex_regwrite, ex_memread,
               ex_rs2_fwd, load_use_stall
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : ID/EX register with EX/MEM + MEM/WB forwarding and load-use bubble
//  Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    alu_operand_stage_if.slave  bus
);
    localparam logic [REG_ADDR_W-1:0] C_R0 = '0;

    logic                  valid_q,    valid_d;
    logic [REG_ADDR_W-1:0] rs1_q,      rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q,      rs2_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    logic [DATA_W-1:0]     rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0]     rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0]     imm_q,      imm_d;
    logic                  use_imm_q,  use_imm_d;
    logic [ALUOP_W-1:0]    aluop_q,    aluop_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memread_q,  memread_d;

    logic                  w_stall;
    logic [DATA_W-1:0]     w_fwd_rs1;
    logic [DATA_W-1:0]     w_fwd_rs2;

    // The load in EX has no data until MEM, so a dependent consumer must wait one cycle.
    always_comb begin
        w_stall = bus.id_valid & valid_q & memread_q & (rd_q != C_R0) &
                  ((rd_q == bus.id_rs1) | (!bus.id_use_imm & (rd_q == bus.id_rs2)));
    end

    always_comb begin
        valid_d    = valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        use_imm_d  = use_imm_q;
        aluop_d    = aluop_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        if (bus.flush || (!bus.hold && w_stall)) begin
            valid_d    = 1'b0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            use_imm_d  = 1'b0;
            aluop_d    = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else if (!bus.hold) begin
            valid_d    = bus.id_valid;
            rs1_d      = bus.id_rs1;
            rs2_d      = bus.id_rs2;
            rd_d       = bus.id_rd;
            rs1_data_d = bus.id_rs1_data;
            rs2_data_d = bus.id_rs2_data;
            imm_d      = bus.id_imm;
            use_imm_d  = bus.id_use_imm;
            aluop_d    = bus.id_aluop;
            regwrite_d = bus.id_regwrite & bus.id_valid;
            memread_d  = bus.id_memread  & bus.id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            aluop_q    <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            use_imm_q  <= use_imm_d;
            aluop_q    <= aluop_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
        end
    end

    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    always_comb begin
        if (bus.exm_regwrite && (bus.exm_rd != C_R0) && (bus.exm_rd == rs1_q)) begin
            w_fwd_rs1 = bus.exm_result;
        end else if (bus.mwb_regwrite && (bus.mwb_rd != C_R0) && (bus.mwb_rd == rs1_q)) begin
            w_fwd_rs1 = bus.mwb_result;
        end else begin
            w_fwd_rs1 = rs1_data_q;
        end

        if (bus.exm_regwrite && (bus.exm_rd != C_R0) && (bus.exm_rd == rs2_q)) begin
            w_fwd_rs2 = bus.exm_result;
        end else if (bus.mwb_regwrite && (bus.mwb_rd != C_R0) && (bus.mwb_rd == rs2_q)) begin
            w_fwd_rs2 = bus.mwb_result;
        end else begin
            w_fwd_rs2 = rs2_data_q;
        end
    end

    assign bus.data1          = w_fwd_rs1;
    assign bus.data2          = use_imm_q ? imm_q : w_fwd_rs2;
    assign bus.ex_rs2_fwd     = w_fwd_rs2;
    assign bus.aluoperation   = aluop_q;
    assign bus.ex_valid       = valid_q;
    assign bus.ex_rd          = rd_q;
    assign bus.ex_regwrite    = regwrite_q & valid_q;
    assign bus.ex_memread     = memread_q & valid_q;
    assign bus.load_use_stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Purpose  : Scoreboard bench for alu_operand_stage
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
    localparam int C_SEL_D1    = 0;
    localparam int C_SEL_D2    = 1;
    localparam int C_SEL_OP    = 2;
    localparam int C_SEL_VALID = 3;
    localparam int C_SEL_RW    = 4;
    localparam int C_SEL_MR    = 5;
    localparam int C_SEL_RS2F  = 6;
    localparam int C_SEL_STALL = 7;
    localparam int C_SEL_RD    = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    alu_operand_stage_if #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(4)) bus ();

    alu_operand_stage #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            C_SEL_D1:    return bus.data1;
            C_SEL_D2:    return bus.data2;
            C_SEL_OP:    return {28'd0, bus.aluoperation};
            C_SEL_VALID: return {31'd0, bus.ex_valid};
            C_SEL_RW:    return {31'd0, bus.ex_regwrite};
            C_SEL_MR:    return {31'd0, bus.ex_memread};
            C_SEL_RS2F:  return bus.ex_rs2_fwd;
            C_SEL_STALL: return {31'd0, bus.load_use_stall};
            C_SEL_RD:    return {27'd0, bus.ex_rd};
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
    endtask

    // Compare after the next rising edge, away from the edge itself.
    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    // Compare combinational outputs without clocking.
    task automatic settle();
        #1;
        drain();
    endtask

    task automatic id_idle();
        bus.id_valid    = 1'b0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
        bus.id_rs1_data = '0;
        bus.id_rs2_data = '0;
        bus.id_imm      = '0;
        bus.id_use_imm  = 1'b0;
        bus.id_aluop    = '0;
        bus.id_regwrite = 1'b0;
        bus.id_memread  = 1'b0;
    endtask

    task automatic id_drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                            input logic use_imm, input logic [3:0] op, input logic rw, input logic mr);
        bus.id_valid    = 1'b1;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_rs1_data = d1;
        bus.id_rs2_data = d2;
        bus.id_imm      = imm;
        bus.id_use_imm  = use_imm;
        bus.id_aluop    = op;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        id_idle();
        bus.hold = 1'b0;
        bus.flush = 1'b0;
        bus.exm_regwrite = 1'b0;
        bus.exm_rd = '0;
        bus.exm_result = '0;
        bus.mwb_regwrite = 1'b0;
        bus.mwb_rd = '0;
        bus.mwb_result = '0;

        // Reset held for two cycles while decode presents a real instruction.
        rst = 1'b1;
        id_drive(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0, 4'd1, 1'b1, 1'b1);
        step();
        expect_val("rst_valid", C_SEL_VALID, 32'd0);
        expect_val("rst_aluop", C_SEL_OP, 32'd0);
        expect_val("rst_regwrite", C_SEL_RW, 32'd0);
        expect_val("rst_memread", C_SEL_MR, 32'd0);
        expect_val("rst_rd", C_SEL_RD, 32'd0);
        step();

        // Plain capture.
        rst = 1'b0;
        id_drive(5'd1, 5'd2, 5'd4, 32'd10, 32'd20, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        expect_val("cap_data1", C_SEL_D1, 32'd10);
        expect_val("cap_data2", C_SEL_D2, 32'd20);
        expect_val("cap_aluop", C_SEL_OP, 32'd0);
        expect_val("cap_valid", C_SEL_VALID, 32'd1);
        expect_val("cap_regwrite", C_SEL_RW, 32'd1);
        expect_val("cap_rd", C_SEL_RD, 32'd4);
        step();

        // Dual forward on a held instruction reading r5 twice.
        id_drive(5'd5, 5'd5, 5'd6, 32'd1, 32'd2, 32'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        expect_val("fw_cap_aluop", C_SEL_OP, 32'd1);
        step();
        bus.hold = 1'b1;
        bus.exm_regwrite = 1'b1; bus.exm_rd = 5'd5; bus.exm_result = 32'd50;
        bus.mwb_regwrite = 1'b1; bus.mwb_rd = 5'd5; bus.mwb_result = 32'd30;
        expect_val("fw_exm_d1", C_SEL_D1, 32'd50);
        expect_val("fw_exm_d2", C_SEL_D2, 32'd50);
        expect_val("fw_exm_rs2f", C_SEL_RS2F, 32'd50);
        settle();
        bus.exm_regwrite = 1'b0;
        expect_val("fw_mwb_d1", C_SEL_D1, 32'd30);
        expect_val("fw_mwb_d2", C_SEL_D2, 32'd30);
        settle();
        bus.mwb_regwrite = 1'b0;
        expect_val("fw_none_d1", C_SEL_D1, 32'd1);
        expect_val("fw_none_d2", C_SEL_D2, 32'd2);
        settle();

        // Hold ignores new decode contents.
        id_drive(5'd7, 5'd8, 5'd9, 32'd77, 32'd88, 32'd0, 1'b0, 4'd3, 1'b0, 1'b0);
        expect_val("hold_d1", C_SEL_D1, 32'd1);
        expect_val("hold_aluop", C_SEL_OP, 32'd1);
        expect_val("hold_rd", C_SEL_RD, 32'd6);
        step();
        bus.hold = 1'b0;

        // r0 is never forwarded; immediate overrides operand 2 but not store data.
        id_drive(5'd0, 5'd6, 5'd7, 32'd0, 32'd11, 32'd7, 1'b1, 4'd4, 1'b1, 1'b0);
        step();
        bus.exm_regwrite = 1'b1; bus.exm_rd = 5'd0; bus.exm_result = 32'd99;
        expect_val("r0_d1", C_SEL_D1, 32'd0);
        expect_val("r0_rs2f", C_SEL_RS2F, 32'd11);
        settle();
        bus.exm_rd = 5'd6;
        expect_val("imm_d2", C_SEL_D2, 32'd7);
        expect_val("imm_rs2f", C_SEL_RS2F, 32'd99);
        expect_val("imm_d1", C_SEL_D1, 32'd0);
        settle();
        bus.exm_regwrite = 1'b0;

        // Load to r3 followed by a consumer of r3.
        id_drive(5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd4, 1'b1, 4'd0, 1'b1, 1'b1);
        expect_val("ld_memread", C_SEL_MR, 32'd1);
        step();
        id_drive(5'd3, 5'd9, 5'd10, 32'd15, 32'd16, 32'd0, 1'b0, 4'd2, 1'b1, 1'b0);
        expect_val("lu_stall", C_SEL_STALL, 32'd1);
        settle();
        expect_val("lu_bubble_valid", C_SEL_VALID, 32'd0);
        expect_val("lu_bubble_memread", C_SEL_MR, 32'd0);
        expect_val("lu_bubble_regwrite", C_SEL_RW, 32'd0);
        step();
        expect_val("lu_stall_clear", C_SEL_STALL, 32'd0);
        settle();
        expect_val("lu_recap_valid", C_SEL_VALID, 32'd1);
        expect_val("lu_recap_aluop", C_SEL_OP, 32'd2);
        expect_val("lu_recap_d1", C_SEL_D1, 32'd15);
        step();

        // Load to r3 then a consumer whose only r3 use is the ignored rs2 slot.
        id_drive(5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd4, 1'b1, 4'd0, 1'b1, 1'b1);
        step();
        id_drive(5'd4, 5'd3, 5'd11, 32'd21, 32'd22, 32'd5, 1'b1, 4'd3, 1'b1, 1'b0);
        expect_val("lu_imm_nostall", C_SEL_STALL, 32'd0);
        settle();

        // Flush beats hold.
        bus.flush = 1'b1;
        bus.hold  = 1'b1;
        expect_val("flush_valid", C_SEL_VALID, 32'd0);
        expect_val("flush_aluop", C_SEL_OP, 32'd0);
        expect_val("flush_d1", C_SEL_D1, 32'd0);
        step();
        bus.flush = 1'b0;
        bus.hold  = 1'b0;

        // Invalid decode slot zeroes control bits.
        id_drive(5'd1, 5'd2, 5'd12, 32'd5, 32'd6, 32'd0, 1'b0, 4'd3, 1'b1, 1'b1);
        bus.id_valid = 1'b0;
        expect_val("inv_valid", C_SEL_VALID, 32'd0);
        expect_val("inv_regwrite", C_SEL_RW, 32'd0);
        expect_val("inv_memread", C_SEL_MR, 32'd0);
        step();

        // Reset during hold clears everything.
        id_drive(5'd1, 5'd2, 5'd13, 32'd44, 32'd45, 32'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        expect_val("pre_rst_valid", C_SEL_VALID, 32'd1);
        step();
        bus.hold = 1'b1;
        rst = 1'b1;
        expect_val("hold_rst_valid", C_SEL_VALID, 32'd0);
        expect_val("hold_rst_aluop", C_SEL_OP, 32'd0);
        expect_val("hold_rst_d1", C_SEL_D1, 32'd0);
        expect_val("hold_rst_rd", C_SEL_RD, 32'd0);
        step();
        rst = 1'b0;
        bus.hold = 1'b0;
        id_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
